// File: rtl/mdu_sequencer_if.sv
// Handshake/bus bundle between the E-stage issue logic and the MDU sequencer.
// Latency: none (wires only).
// Backpressure: none here; the issuer watches busy and never starts while it is high.
//   start/op/rs_val/rt_val/cancel : issuer -> sequencer
//   busy/done/hi/lo               : sequencer -> issuer
interface mdu_sequencer_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer owning HI/LO; models MDU latency with a countdown.
// Latency: mult/multu MULT_CYCLES busy cycles, div/divu DIV_CYCLES, result + done the cycle after;
// mthi/mtlo write on the accepting edge. Backpressure: starts during RUN are dropped (hazard unit kills them).
//   clk, reset (async active-low), mdu (slave): start/op/rs_val/rt_val/cancel in, busy/done/hi/lo out.
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic            clk,
  input  logic            reset,
  mdu_sequencer_if.slave  mdu
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;

  // Result datapath, always computed from the latched operands.
  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic [31:0] b_safe, q_s, r_s, q_u, r_u;
  logic        div_ovf;

  always_comb begin
    a_sx    = {{32{a_q[31]}}, a_q};
    b_sx    = {{32{b_q[31]}}, b_q};
    prod_s  = a_sx * b_sx;
    prod_u  = {32'd0, a_q} * {32'd0, b_q};
    // A zero divisor never commits a result; substitute 1 so the divider never sees x/0.
    b_safe  = (b_q == 32'd0) ? 32'd1 : b_q;
    q_s     = $signed(a_q) / $signed(b_safe);
    r_s     = $signed(a_q) % $signed(b_safe);
    q_u     = a_q / b_safe;
    r_u     = a_q % b_safe;
    // Most-negative / -1 overflows; the architected answer is quotient=dividend, remainder=0.
    div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (mdu.start && !mdu.cancel) begin
          case (mdu.op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              a_d     = mdu.rs_val;
              b_d     = mdu.rt_val;
              op_d    = mdu.op;
              cnt_d   = (mdu.op == OP_MULT || mdu.op == OP_MULTU) ?
                        CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            OP_MTHI: hi_d = mdu.rs_val;
            OP_MTLO: lo_d = mdu.rs_val;
            default: ;
          endcase
        end
      end
      RUN: begin
        // start is ignored here; cancel wins over the final countdown edge.
        if (mdu.cancel) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV: begin
              if (b_q != 32'd0) begin
                lo_d = div_ovf ? 32'h8000_0000 : q_s;
                hi_d = div_ovf ? 32'd0 : r_s;
              end
            end
            OP_DIVU: begin
              if (b_q != 32'd0) begin
                lo_d = q_u;
                hi_d = r_u;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

  assign mdu.busy = busy_q;
  assign mdu.done = done_q;
  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: vector table plus hand-written corner sequences.
// Latency: expected busy lengths 5 (mult) / 10 (div); results checked on the done pulse.
// Backpressure: bench never issues while busy except in the deliberate ignored-start case.
module tb_mdu_sequencer;

  logic clk;
  logic reset;
  mdu_sequencer_if mif();

  mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard of expected {hi, lo} per committed result.
  logic [63:0] sb[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_n;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Every done pulse must match the oldest outstanding expected result.
  always @(negedge clk) begin
    if (reset && mif.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done expected=no_done hi=%h lo=%h", mif.hi, mif.lo);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("sb_hi", mif.hi, e[63:32]);
        chk("sb_lo", mif.lo, e[31:0]);
      end
    end
  end

  task automatic start_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    mif.start = 1'b1; mif.op = op; mif.rs_val = rs; mif.rt_val = rt;
    @(negedge clk);
    mif.start = 1'b0; mif.op = 3'd0;
  endtask

  // Counts busy cycles from the current negedge; stops at the negedge where busy has dropped.
  task automatic count_busy(output int n);
    n = 0;
    while (mif.busy && n < 60) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    if (v.exp_n > 0) sb.push_back({v.exp_hi, v.exp_lo});
    start_op(v.op, v.rs, v.rt);
    count_busy(n);
    chk($sformatf("vec%0d_busy_cycles", idx), 32'(n), 32'(v.exp_n));
    if (v.exp_n == 0) begin
      chk($sformatf("vec%0d_hi", idx), mif.hi, v.exp_hi);
      chk($sformatf("vec%0d_lo", idx), mif.lo, v.exp_lo);
    end else begin
      chk($sformatf("vec%0d_done", idx), 32'(mif.done), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;

    vecs[0]  = '{3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10};
    vecs[4]  = '{3'd5, 32'h00000011, 32'd0,        32'h00000011, 32'h7FFFFFFC, 0};
    vecs[5]  = '{3'd6, 32'h00000022, 32'd0,        32'h00000011, 32'h00000022, 0};
    vecs[6]  = '{3'd3, 32'h00000064, 32'd0,        32'h00000011, 32'h00000022, 10};
    vecs[7]  = '{3'd7, 32'h12345678, 32'd3,        32'h00000011, 32'h00000022, 0};
    vecs[8]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[9]  = '{3'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    vecs[10] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[11] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[12] = '{3'd0, 32'hDEADBEEF, 32'd9,        32'h40000000, 32'h00000000, 0};

    mif.start = 1'b0; mif.op = 3'd0; mif.rs_val = '0; mif.rt_val = '0; mif.cancel = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(mif.busy), 32'd0);
    chk("reset_done", 32'(mif.done), 32'd0);
    chk("reset_hi", mif.hi, 32'd0);
    chk("reset_lo", mif.lo, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Start during RUN is dropped: only the mult result appears, busy lasts 5 cycles.
    sb.push_back({32'hFFFFFFFF, 32'hFFFFFFEB});
    start_op(3'd1, 32'd7, 32'hFFFFFFFD);
    n = 0;
    while (mif.busy && n < 60) begin
      n++;
      if (n == 2) begin mif.start = 1'b1; mif.op = 3'd3; mif.rs_val = 32'd100; mif.rt_val = 32'd7; end
      if (n == 3) begin mif.start = 1'b0; mif.op = 3'd0; end
      @(negedge clk);
    end
    chk("ignored_start_busy_cycles", 32'(n), 32'd5);
    seen = 1'b0;
    repeat (15) begin @(negedge clk); if (mif.busy) seen = 1'b1; end
    chk("ignored_start_no_busy", 32'(seen), 32'd0);

    // mthi in IDLE.
    start_op(3'd5, 32'h0000ABCD, 32'd0);
    chk("mthi_hi", mif.hi, 32'h0000ABCD);
    chk("mthi_busy", 32'(mif.busy), 32'd0);

    // Back-to-back: issue in the done cycle.
    sb.push_back({32'd0, 32'd6});
    start_op(3'd1, 32'd2, 32'd3);
    count_busy(n);
    chk("b2b_first_done", 32'(mif.done), 32'd1);
    sb.push_back({32'd0, 32'd12});
    mif.start = 1'b1; mif.op = 3'd2; mif.rs_val = 32'd3; mif.rt_val = 32'd4;
    @(negedge clk);
    mif.start = 1'b0; mif.op = 3'd0;
    chk("b2b_second_busy", 32'(mif.busy), 32'd1);
    count_busy(n);
    chk("b2b_second_busy_cycles", 32'(n), 32'd5);

    // Cancel at busy cycle 2 of a div.
    start_op(3'd3, 32'd100, 32'd7);
    @(negedge clk);
    mif.cancel = 1'b1;
    @(negedge clk);
    mif.cancel = 1'b0;
    chk("cancel_div_busy", 32'(mif.busy), 32'd0);
    repeat (12) @(negedge clk);
    chk("cancel_div_hi", mif.hi, 32'd0);
    chk("cancel_div_lo", mif.lo, 32'd12);

    // Cancel on the final countdown cycle beats completion.
    start_op(3'd1, 32'd5, 32'd5);
    repeat (4) @(negedge clk);
    chk("cancel_last_still_busy", 32'(mif.busy), 32'd1);
    mif.cancel = 1'b1;
    @(negedge clk);
    mif.cancel = 1'b0;
    chk("cancel_last_busy", 32'(mif.busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("cancel_last_lo", mif.lo, 32'd12);

    // Cancel in IDLE suppresses a start.
    @(negedge clk);
    mif.start = 1'b1; mif.op = 3'd1; mif.rs_val = 32'd9; mif.rt_val = 32'd9; mif.cancel = 1'b1;
    @(negedge clk);
    mif.start = 1'b0; mif.op = 3'd0; mif.cancel = 1'b0;
    chk("cancel_idle_busy", 32'(mif.busy), 32'd0);

    // Async reset mid-mult clears everything immediately.
    start_op(3'd5, 32'h55, 32'd0);
    start_op(3'd1, 32'd5, 32'd5);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 32'(mif.busy), 32'd0);
    chk("arst_done", 32'(mif.done), 32'd0);
    chk("arst_hi", mif.hi, 32'd0);
    chk("arst_lo", mif.lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_arst_idle", 32'(mif.busy), 32'd0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
